// File: rtl/mdu_defs.sv
// -----------------------------------------------------------------------------
// mdu_defs
// Shared definitions for the multiply/divide unit. The controller and the
// datapath both use these so the MDUop encoding lives in exactly one place.
//   mdu_op_e     : MDUop encodings driven by the controller
//   mdu_state_e  : IDLE (counter == 0) / RUN (counter != 0) view of the counter
//   MDU_*_CYCLES : default Busy lengths for multiply and divide
// -----------------------------------------------------------------------------
package mdu_defs;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith
// Purely combinational arithmetic core of the MDU. Produces the {hi, lo} pair
// for mult/multu/div/divu and flags a divide by zero so the sequencer can
// suppress the write-back.
//   i_op          : operation (only MULT..DIVU produce a result)
//   i_a, i_b      : operands rs / rt
//   o_hi, o_lo    : result (product high/low, or remainder/quotient)
//   o_divByZero   : high for div/divu with i_b == 0
// -----------------------------------------------------------------------------
module mdu_arith
    import mdu_defs::*;
(
    input  mdu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_divByZero
);

    logic signed [63:0] w_sProd;
    logic        [63:0] w_uProd;
    logic               w_bZero;
    logic               w_sOverflow;
    logic        [31:0] w_sDivisor;
    logic        [31:0] w_uDivisor;
    logic signed [31:0] w_sQuot;
    logic signed [31:0] w_sRem;
    logic        [31:0] w_uQuot;
    logic        [31:0] w_uRem;

    // Full-width products: sign-extend for mult, zero-extend for multu.
    assign w_sProd = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_uProd = {32'd0, i_a} * {32'd0, i_b};

    assign w_bZero     = (i_b == 32'd0);
    assign w_sOverflow = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // The divider never sees a zero divisor, and the signed one never sees
    // INT_MIN / -1. Substituting 1 for the overflow case yields exactly the
    // architectural answer (quotient = dividend, remainder = 0), so no extra
    // mux is needed for it. The divide-by-zero result is discarded anyway.
    assign w_sDivisor = (w_bZero || w_sOverflow) ? 32'd1 : i_b;
    assign w_uDivisor = w_bZero ? 32'd1 : i_b;

    // Verilog signed / and % truncate toward zero with the remainder taking
    // the dividend's sign, which is the MIPS definition.
    assign w_sQuot = $signed(i_a) / $signed(w_sDivisor);
    assign w_sRem  = $signed(i_a) % $signed(w_sDivisor);
    assign w_uQuot = i_a / w_uDivisor;
    assign w_uRem  = i_a % w_uDivisor;

    // Result select by op; anything that is not an arithmetic op yields zero.
    always_comb begin
        o_hi        = 32'd0;
        o_lo        = 32'd0;
        o_divByZero = 1'b0;
        case (i_op)
            MDU_MULT: begin
                o_hi = w_sProd[63:32];
                o_lo = w_sProd[31:0];
            end
            MDU_MULTU: begin
                o_hi = w_uProd[63:32];
                o_lo = w_uProd[31:0];
            end
            MDU_DIV: begin
                o_hi        = w_sRem;
                o_lo        = w_sQuot;
                o_divByZero = w_bZero;
            end
            MDU_DIVU: begin
                o_hi        = w_uRem;
                o_lo        = w_uQuot;
                o_divByZero = w_bZero;
            end
            default: begin
                o_hi        = 32'd0;
                o_lo        = 32'd0;
                o_divByZero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit
// Multi-cycle multiply/divide unit with architectural HI/LO registers. The
// result is computed at the Start edge and held in pending registers while a
// down-counter models the multi-cycle latency; HI/LO update when it expires.
//   CLK    : clock, all state on rising edge
//   RESET  : synchronous active-high reset, dominates Start
//   Start  : one-cycle request qualified by MDUop
//   MDUop  : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 rsvd
//   A, B   : operands rs / rt, sampled only at an accepted Start edge
//   Busy   : high while an operation is in flight
//   HI, LO : architectural registers (no bypass of pending results)
// -----------------------------------------------------------------------------
module mdu_unit
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pendHi;
    logic [31:0]      r_pendLo;
    logic             r_pendWrite;

    logic [CNT_W-1:0] w_countNext;
    logic [31:0]      w_hiNext;
    logic [31:0]      w_loNext;
    logic [31:0]      w_pendHiNext;
    logic [31:0]      w_pendLoNext;
    logic             w_pendWriteNext;

    mdu_op_e          w_op;
    mdu_state_e       w_state;
    logic [31:0]      w_arithHi;
    logic [31:0]      w_arithLo;
    logic             w_divByZero;

    assign w_op    = mdu_op_e'(MDUop);
    assign w_state = (r_count == '0) ? ST_IDLE : ST_RUN;

    mdu_arith u_arith (
        .i_op        (w_op),
        .i_a         (A),
        .i_b         (B),
        .o_hi        (w_arithHi),
        .o_lo        (w_arithLo),
        .o_divByZero (w_divByZero)
    );

    // Next-state logic. The counter is the state: in RUN every request is
    // ignored and the counter just ticks down, committing the pending pair on
    // the 1 -> 0 step. In IDLE a Start either launches an arithmetic op or
    // performs an immediate mthi/mtlo. A divide by zero still runs the full
    // latency but leaves the pending write disarmed.
    always_comb begin
        w_countNext     = r_count;
        w_hiNext        = r_hi;
        w_loNext        = r_lo;
        w_pendHiNext    = r_pendHi;
        w_pendLoNext    = r_pendLo;
        w_pendWriteNext = r_pendWrite;
        case (w_state)
            ST_RUN: begin
                w_countNext = r_count - CNT_ONE;
                if (r_count == CNT_ONE) begin
                    w_pendWriteNext = 1'b0;
                    if (r_pendWrite) begin
                        w_hiNext = r_pendHi;
                        w_loNext = r_pendLo;
                    end
                end
            end
            ST_IDLE: begin
                if (Start) begin
                    case (w_op)
                        MDU_MULT, MDU_MULTU: begin
                            w_countNext     = MULT_LOAD;
                            w_pendHiNext    = w_arithHi;
                            w_pendLoNext    = w_arithLo;
                            w_pendWriteNext = 1'b1;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            w_countNext     = DIV_LOAD;
                            w_pendHiNext    = w_arithHi;
                            w_pendLoNext    = w_arithLo;
                            w_pendWriteNext = !w_divByZero;
                        end
                        MDU_MTHI: w_hiNext = A;
                        MDU_MTLO: w_loNext = A;
                        default: begin
                            w_countNext = r_count;
                        end
                    endcase
                end
            end
            default: begin
                w_countNext = '0;
            end
        endcase
    end

    // State register. Reset aborts any operation in flight and clears
    // everything, including the pending pair.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count     <= '0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_pendHi    <= 32'd0;
            r_pendLo    <= 32'd0;
            r_pendWrite <= 1'b0;
        end else begin
            r_count     <= w_countNext;
            r_hi        <= w_hiNext;
            r_lo        <= w_loNext;
            r_pendHi    <= w_pendHiNext;
            r_pendLo    <= w_pendLoNext;
            r_pendWrite <= w_pendWriteNext;
        end
    end

    assign Busy = (w_state == ST_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit
// Self-checking bench for mdu_unit with default latencies (5 / 10). A
// behavioural model tracks HI/LO and the edge at which the current operation
// completes; a compare process checks Busy/HI/LO against it every cycle, and
// the directed sequence also checks hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_mdu_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [2:0]  MDUop;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int nChecks = 0;
    int nPass   = 0;
    logic checkEn = 1'b0;

    // Model state: current edge number, edge at which the in-flight op
    // completes, and the result it will commit (if any).
    int          edgeNo   = 0;
    int          doneEdge = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    logic [31:0] mPendHi = 32'd0;
    logic [31:0] mPendLo = 32'd0;
    logic        mPendValid = 1'b0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .Start (Start),
        .MDUop (MDUop),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 CLK = ~CLK;

    // Record one comparison and report it if it differs.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Architectural result of an arithmetic op computed with plain integer math.
    task automatic modelResult(input int op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] hi, output logic [31:0] lo, output logic wr);
        int sa, sb, q, r;
        longint sp;
        longint unsigned up;
        logic [63:0] p;
        sa = a; sb = b; hi = 32'd0; lo = 32'd0; wr = 1'b1; p = 64'd0;
        case (op)
            1: begin sp = longint'(sa) * longint'(sb); p = sp; hi = p[63:32]; lo = p[31:0]; end
            2: begin up = longint'(a) * longint'(b); p = up; hi = p[63:32]; lo = p[31:0]; end
            3: begin
                if (sb == 0) wr = 1'b0;
                else if (sa == int'(32'h8000_0000) && sb == -1) begin lo = a; hi = 32'd0; end
                else begin q = sa / sb; r = sa % sb; lo = q; hi = r; end
            end
            4: begin
                if (b == 32'd0) wr = 1'b0;
                else begin lo = a / b; hi = a % b; end
            end
            default: wr = 1'b0;
        endcase
    endtask

    // Model update on each rising edge from the inputs the DUT also sees.
    always @(posedge CLK) begin
        logic [31:0] h, l;
        logic w;
        edgeNo++;
        if (RESET) begin
            mHi = 32'd0; mLo = 32'd0; doneEdge = 0; mPendValid = 1'b0;
        end else if (edgeNo <= doneEdge) begin
            if (edgeNo == doneEdge && mPendValid) begin mHi = mPendHi; mLo = mPendLo; end
        end else if (Start) begin
            case (MDUop)
                3'd1, 3'd2: begin
                    modelResult(int'(MDUop), A, B, h, l, w);
                    mPendHi = h; mPendLo = l; mPendValid = w; doneEdge = edgeNo + 5;
                end
                3'd3, 3'd4: begin
                    modelResult(int'(MDUop), A, B, h, l, w);
                    mPendHi = h; mPendLo = l; mPendValid = w; doneEdge = edgeNo + 10;
                end
                3'd5: mHi = A;
                3'd6: mLo = A;
                default: ;
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("model busy", {31'd0, Busy}, {31'd0, (edgeNo < doneEdge)});
            checkOutput("model HI", HI, mHi);
            checkOutput("model LO", LO, mLo);
        end
    end

    // Drive one Start pulse (called at a falling edge); returns at the falling
    // edge after the Start edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDUop = op; A = a; B = b;
        @(negedge CLK);
        Start = 1'b0; MDUop = 3'd0;
    endtask

    // Count falling edges with Busy high, bounded.
    task automatic waitIdle(output int n);
        n = 0;
        while (Busy && n < 60) begin n++; @(negedge CLK); end
    endtask

    initial begin
        int n;
        RESET = 1'b1; Start = 1'b0; MDUop = 3'd0; A = 32'd0; B = 32'd0;
        @(negedge CLK);
        checkEn = 1'b1;
        checkOutput("reset busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3); waitIdle(n);
        checkOutput("mult busy cycles", n, 32'd5);
        checkOutput("mult HI", HI, 32'hFFFF_FFFF);
        checkOutput("mult LO", LO, 32'hFFFF_FFFA);

        applyStimulus(3'd2, 32'hFFFF_FFFE, 32'd3); waitIdle(n);
        checkOutput("multu busy cycles", n, 32'd5);
        checkOutput("multu HI", HI, 32'h0000_0002);
        checkOutput("multu LO", LO, 32'hFFFF_FFFA);

        applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2); waitIdle(n);
        checkOutput("div busy cycles", n, 32'd10);
        checkOutput("div HI", HI, 32'hFFFF_FFFF);
        checkOutput("div LO", LO, 32'hFFFF_FFFD);

        applyStimulus(3'd4, 32'd7, 32'd0); waitIdle(n);
        checkOutput("divu0 busy cycles", n, 32'd10);
        checkOutput("divu0 HI", HI, 32'hFFFF_FFFF);
        checkOutput("divu0 LO", LO, 32'hFFFF_FFFD);

        applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); waitIdle(n);
        checkOutput("divovf HI", HI, 32'd0);
        checkOutput("divovf LO", LO, 32'h8000_0000);

        // mthi on the first edge after Busy falls
        applyStimulus(3'd5, 32'h1234_5678, 32'd0);
        checkOutput("mthi HI", HI, 32'h1234_5678);
        checkOutput("mthi LO", LO, 32'h8000_0000);
        checkOutput("mthi busy", {31'd0, Busy}, 32'd0);

        // mult 6*7 with operand changes and an mtlo attempt while busy
        applyStimulus(3'd1, 32'd6, 32'd7);
        n = 0;
        while (Busy && n < 60) begin
            n++;
            if (n == 2) begin A = 32'd9; B = 32'd9; end
            if (n == 3) begin Start = 1'b1; MDUop = 3'd6; A = 32'h0000_DEAD; end
            if (n == 4) begin Start = 1'b0; MDUop = 3'd0; end
            @(negedge CLK);
        end
        checkOutput("ignored busy cycles", n, 32'd5);
        checkOutput("ignored HI", HI, 32'd0);
        checkOutput("ignored LO", LO, 32'd42);

        applyStimulus(3'd4, 32'd100, 32'd7); waitIdle(n);
        checkOutput("divu HI", HI, 32'd2);
        checkOutput("divu LO", LO, 32'd14);

        applyStimulus(3'd3, 32'd7, 32'hFFFF_FFFE); waitIdle(n);
        checkOutput("div neg HI", HI, 32'd1);
        checkOutput("div neg LO", LO, 32'hFFFF_FFFD);

        applyStimulus(3'd7, 32'h5555_5555, 32'd1);
        applyStimulus(3'd0, 32'h6666_6666, 32'd1);
        checkOutput("noop busy", {31'd0, Busy}, 32'd0);
        checkOutput("noop HI", HI, 32'd1);
        checkOutput("noop LO", LO, 32'hFFFF_FFFD);

        applyStimulus(3'd6, 32'h0000_CAFE, 32'd0);
        checkOutput("mtlo LO", LO, 32'h0000_CAFE);
        checkOutput("mtlo HI", HI, 32'd1);

        // div aborted by reset on its fourth edge
        applyStimulus(3'd3, 32'd100, 32'd7);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checkOutput("abort busy", {31'd0, Busy}, 32'd0);
        checkOutput("abort HI", HI, 32'd0);
        checkOutput("abort LO", LO, 32'd0);
        repeat (15) @(negedge CLK);
        checkOutput("abort late HI", HI, 32'd0);
        checkOutput("abort late LO", LO, 32'd0);
        checkOutput("abort late busy", {31'd0, Busy}, 32'd0);

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
